// File: rtl/mod_step_counter.sv
// Modulo step counter for the signal-generator address path: programmable step,
// runtime modulus, up/down, parallel load and a one-shot single-period mode.
module mod_step_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] incr,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic             busy_nxt;

  logic [W1-1:0]    sum;
  logic [W1-1:0]    diff;
  logic [W1-1:0]    fold;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             advance;

  // Candidate next count and wrap flag for one advance in the current direction.
  always_comb begin
    sum       = W1'(count) + W1'(incr);
    diff      = W1'(count) - W1'(incr);
    fold      = W1'(count) + W1'(limit) - W1'(incr);
    step_val  = count;
    step_wrap = 1'b0;
    if (!dir) begin
      if (limit == '0) begin
        step_val  = sum[WIDTH-1:0];
        step_wrap = sum[WIDTH];
      end else if (sum >= W1'(limit)) begin
        step_val  = WIDTH'(sum - W1'(limit));
        step_wrap = 1'b1;
      end else begin
        step_val  = sum[WIDTH-1:0];
      end
    end else begin
      if (limit == '0) begin
        step_val  = diff[WIDTH-1:0];
        step_wrap = diff[WIDTH];
      end else if (count >= incr) begin
        step_val  = count - incr;
      end else begin
        step_val  = fold[WIDTH-1:0];
        step_wrap = 1'b1;
      end
    end
  end

  assign advance = en && (!mode || (state == RUN));

  // Next-state and registered-output logic; ld freezes the FSM.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (ld) begin
      count_nxt = ld_val;
    end else begin
      if (!mode) begin
        state_nxt = IDLE;
      end else if ((state == IDLE) && start) begin
        state_nxt = RUN;
      end
      if (advance) begin
        count_nxt = step_val;
        wrap_nxt  = step_wrap;
        if (mode && (state == RUN) && step_wrap) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    end
    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model.
module tb_mod_step_counter;

  localparam int unsigned W   = 8;
  localparam int          MOD = 256;

  logic         clk = 1'b0;
  logic         rst, en, dir, mode, start, ld;
  logic [W-1:0] incr, limit, ld_val;
  logic [W-1:0] count;
  logic         wrap, done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  int m_count;
  int m_wrap, m_done, m_run;

  mod_step_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .incr(incr), .limit(limit), .dir(dir),
    .mode(mode), .start(start), .ld(ld), .ld_val(ld_val),
    .count(count), .wrap(wrap), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrapmod(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  // Reference model: one clock's worth of the counter rules in plain integers.
  task automatic model_step();
    int s, l, c, i, was_run, adv;
    if (rst) begin
      m_count = 0; m_wrap = 0; m_done = 0; m_run = 0;
      return;
    end
    m_wrap = 0; m_done = 0;
    if (ld) begin
      m_count = int'(ld_val);
      return;
    end
    c = m_count; i = int'(incr); l = int'(limit);
    was_run = m_run;
    adv = (en && (!mode || was_run)) ? 1 : 0;
    if (!mode) m_run = 0;
    else if (!was_run && start) m_run = 1;
    if (adv != 0) begin
      if (!dir) begin
        s = c + i;
        if (l == 0) begin m_count = s % MOD; m_wrap = (s >= MOD) ? 1 : 0; end
        else if (s >= l) begin m_count = wrapmod(s - l); m_wrap = 1; end
        else m_count = s;
      end else begin
        if (l == 0) begin m_count = wrapmod(c - i); m_wrap = (c < i) ? 1 : 0; end
        else if (c >= i) m_count = c - i;
        else begin m_count = wrapmod(c + l - i); m_wrap = 1; end
      end
      if (mode && was_run && m_wrap) begin m_run = 0; m_done = 1; end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".count"}, int'(count), m_count);
    chk({tag, ".wrap"},  int'(wrap),  m_wrap);
    chk({tag, ".done"},  int'(done),  m_done);
    chk({tag, ".busy"},  int'(busy),  m_run);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; start = 1'b0; ld = 1'b0;
    incr = '0; limit = '0; ld_val = '0;
    m_count = 0; m_wrap = 0; m_done = 0; m_run = 0;
    #1;
    tick("reset0");
    tick("reset1");
    chk("reset_count_const", int'(count), 0);
    rst = 1'b0;

    // continuous up, limit 10, step 3
    limit = 8'd10; incr = 8'd3; en = 1'b1;
    tick("up1"); chk("up1_const", int'(count), 3);
    tick("up2"); chk("up2_const", int'(count), 6);
    tick("up3"); chk("up3_const", int'(count), 9);
    tick("up4"); chk("up4_const", int'(count), 2); chk("up4_wrap_const", int'(wrap), 1);

    // down wrap from a loaded value
    ld = 1'b1; ld_val = 8'd2; tick("dnld");
    ld = 1'b0; dir = 1'b1; incr = 8'd4;
    tick("dn1"); chk("dn1_const", int'(count), 8); chk("dn1_wrap_const", int'(wrap), 1);
    tick("dn2"); chk("dn2_const", int'(count), 4);
    tick("dn3"); chk("dn3_const", int'(count), 0); chk("dn3_wrap_const", int'(wrap), 0);

    // full range
    dir = 1'b0; limit = 8'd0; ld = 1'b1; ld_val = 8'd100; tick("fr_ld");
    ld = 1'b0; incr = 8'd200;
    tick("fr_up"); chk("fr_up_const", int'(count), 44);
    dir = 1'b1; incr = 8'd50;
    tick("fr_dn"); chk("fr_dn_const", int'(count), 250); chk("fr_dn_wrap_const", int'(wrap), 1);

    // one-shot
    dir = 1'b0; ld = 1'b1; ld_val = 8'd0; tick("os_ld");
    ld = 1'b0; mode = 1'b1; limit = 8'd4; incr = 8'd1; start = 1'b1;
    tick("os_arm"); chk("os_arm_busy_const", int'(busy), 1);
    start = 1'b0;
    tick("os1"); tick("os2"); tick("os3");
    tick("os4"); chk("os4_done_const", int'(done), 1); chk("os4_count_const", int'(count), 0);
    tick("os5"); chk("os5_busy_const", int'(busy), 0);
    tick("os6"); chk("os6_count_const", int'(count), 0);

    // priority: ld over advance, rst aborts a run
    mode = 1'b0; ld = 1'b1; ld_val = 8'd7;
    tick("pr_ld"); chk("pr_ld_const", int'(count), 7); chk("pr_ld_wrap_const", int'(wrap), 0);
    ld = 1'b0; mode = 1'b1; start = 1'b1; limit = 8'd20;
    tick("pr_arm"); start = 1'b0;
    tick("pr_run1"); tick("pr_run2");
    rst = 1'b1;
    tick("pr_rst"); chk("pr_rst_busy_const", int'(busy), 0);
    rst = 1'b0;

    // hold with en low in both modes
    ld = 1'b1; ld_val = 8'd13; tick("hold_ld"); ld = 1'b0;
    en = 1'b0; mode = 1'b0;
    for (int k = 0; k < 5; k++) tick("hold_cont");
    chk("hold_cont_const", int'(count), 13);
    mode = 1'b1; start = 1'b1; tick("hold_arm"); start = 1'b0;
    for (int k = 0; k < 5; k++) tick("hold_os");
    chk("hold_os_const", int'(count), 13);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 60) == 0);
      ld    = ($urandom_range(0, 15) == 0);
      ld_val = W'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 20) == 0) mode = ~mode;
      if ($urandom_range(0, 10) == 0) dir = ~dir;
      if ($urandom_range(0, 30) == 0) begin
        case ($urandom_range(0, 2))
          0:       limit = '0;
          1:       limit = W'($urandom_range(1, 16));
          default: limit = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 8) == 0)
        incr = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
